light_hash_des: RTL and testbench

LIGHT_HASH_DES -- requirements
Module: light_hash_des

---
 rtl/light_hash_des.sv | 152 +++++++++++++++
 tb/tb_light_hash_des.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/light_hash_des.sv
// Byte-serial 32-bit hash: every message byte is mixed into the state through the
// eight DES S-boxes, then a fold of the message length is mixed in to give the digest.
module light_hash_des (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_valid,
    input  logic [7:0]  M,
    input  logic [63:0] input_lenght,
    output logic        hash_ready,
    output logic [31:0] digest
);

    localparam logic [31:0] IV = 32'h3D7A_9C15;

    // DES S1..S8, each flattened as row*16 + column
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
          4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
          4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
          4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
        '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
          4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
          4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
          4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
        '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
          4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
          4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
        '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
          4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
          4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
          4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
        '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
          4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
          4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
          4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
        '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
          4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
          4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
          4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
        '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
          4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
          4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
          4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
        '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
          4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
          4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
          4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    };

    typedef enum logic [1:0] {IDLE, ABSORB, FINAL, DONE} state_t;

    // Nibble i is wrapped by two neighbouring byte bits to form the 6-bit S-box input
    function automatic logic [31:0] roundFn(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] n;
        logic [5:0]  x;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            x = {b[i], h[4*i +: 4], b[3'(i + 7)]};
            n[4*i +: 4] = SBOX[i][{x[5], x[0], x[4:1]}];
        end
        return {n[26:0], n[31:27]} ^ h;
    endfunction

    state_t      r_state;
    logic [31:0] r_hash;
    logic [63:0] r_count;
    logic [63:0] r_len;
    logic        r_ready;
    logic [31:0] r_digest;

    state_t      w_stateNext;
    logic [31:0] w_hashNext;
    logic [63:0] w_countNext;
    logic [63:0] w_lenNext;
    logic        w_readyNext;
    logic [31:0] w_digestNext;

    logic [31:0] w_roundH;
    logic [7:0]  w_roundB;
    logic [31:0] w_round;
    logic [63:0] w_lenEff;
    logic [7:0]  w_lenFold;

    assign w_lenEff  = (input_lenght == 64'd0) ? 64'd1 : input_lenght;
    assign w_lenFold = r_len[7:0]   ^ r_len[15:8]  ^ r_len[23:16] ^ r_len[31:24] ^
                       r_len[39:32] ^ r_len[47:40] ^ r_len[55:48] ^ r_len[63:56];

    // A single round instance is shared: the first byte starts from IV, FINAL mixes in the length fold
    assign w_roundH = (r_state == ABSORB || r_state == FINAL) ? r_hash : IV;
    assign w_roundB = (r_state == FINAL) ? w_lenFold : M;
    assign w_round  = roundFn(w_roundH, w_roundB);

    always_comb begin
        w_stateNext  = r_state;
        w_hashNext   = r_hash;
        w_countNext  = r_count;
        w_lenNext    = r_len;
        w_readyNext  = r_ready;
        w_digestNext = r_digest;
        case (r_state)
            IDLE, DONE: begin
                if (M_valid) begin
                    w_lenNext   = w_lenEff;
                    w_hashNext  = w_round;
                    w_countNext = 64'd1;
                    w_readyNext = 1'b0;
                    w_stateNext = (w_lenEff == 64'd1) ? FINAL : ABSORB;
                end
            end
            ABSORB: begin
                if (M_valid) begin
                    w_hashNext  = w_round;
                    w_countNext = r_count + 64'd1;
                    if (r_count + 64'd1 == r_len) begin
                        w_stateNext = FINAL;
                    end
                end
            end
            FINAL: begin
                w_hashNext   = w_round;
                w_digestNext = w_round;
                w_readyNext  = 1'b1;
                w_stateNext  = DONE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state  <= IDLE;
            r_hash   <= IV;
            r_count  <= 64'd0;
            r_len    <= 64'd0;
            r_ready  <= 1'b0;
            r_digest <= 32'h0;
        end else begin
            r_state  <= w_stateNext;
            r_hash   <= w_hashNext;
            r_count  <= w_countNext;
            r_len    <= w_lenNext;
            r_ready  <= w_readyNext;
            r_digest <= w_digestNext;
        end
    end

    assign hash_ready = r_ready;
    assign digest     = r_digest;

endmodule

// File: tb/tb_light_hash_des.sv
// Bench for light_hash_des: table of messages checked against a reference hash model
// through a digest scoreboard, plus hand-written reset and latency sequences.
module tb_light_hash_des;

    localparam logic [31:0] IV = 32'h3D7A_9C15;

    // Reference S-boxes in FIPS row/column form
    localparam logic [3:0] TB_SBOX [8][4][16] = '{
        '{'{4'd14,4'd4,4'd13,4'd1,4'd2,4'd15,4'd11,4'd8,4'd3,4'd10,4'd6,4'd12,4'd5,4'd9,4'd0,4'd7},
          '{4'd0,4'd15,4'd7,4'd4,4'd14,4'd2,4'd13,4'd1,4'd10,4'd6,4'd12,4'd11,4'd9,4'd5,4'd3,4'd8},
          '{4'd4,4'd1,4'd14,4'd8,4'd13,4'd6,4'd2,4'd11,4'd15,4'd12,4'd9,4'd7,4'd3,4'd10,4'd5,4'd0},
          '{4'd15,4'd12,4'd8,4'd2,4'd4,4'd9,4'd1,4'd7,4'd5,4'd11,4'd3,4'd14,4'd10,4'd0,4'd6,4'd13}},
        '{'{4'd15,4'd1,4'd8,4'd14,4'd6,4'd11,4'd3,4'd4,4'd9,4'd7,4'd2,4'd13,4'd12,4'd0,4'd5,4'd10},
          '{4'd3,4'd13,4'd4,4'd7,4'd15,4'd2,4'd8,4'd14,4'd12,4'd0,4'd1,4'd10,4'd6,4'd9,4'd11,4'd5},
          '{4'd0,4'd14,4'd7,4'd11,4'd10,4'd4,4'd13,4'd1,4'd5,4'd8,4'd12,4'd6,4'd9,4'd3,4'd2,4'd15},
          '{4'd13,4'd8,4'd10,4'd1,4'd3,4'd15,4'd4,4'd2,4'd11,4'd6,4'd7,4'd12,4'd0,4'd5,4'd14,4'd9}},
        '{'{4'd10,4'd0,4'd9,4'd14,4'd6,4'd3,4'd15,4'd5,4'd1,4'd13,4'd12,4'd7,4'd11,4'd4,4'd2,4'd8},
          '{4'd13,4'd7,4'd0,4'd9,4'd3,4'd4,4'd6,4'd10,4'd2,4'd8,4'd5,4'd14,4'd12,4'd11,4'd15,4'd1},
          '{4'd13,4'd6,4'd4,4'd9,4'd8,4'd15,4'd3,4'd0,4'd11,4'd1,4'd2,4'd12,4'd5,4'd10,4'd14,4'd7},
          '{4'd1,4'd10,4'd13,4'd0,4'd6,4'd9,4'd8,4'd7,4'd4,4'd15,4'd14,4'd3,4'd11,4'd5,4'd2,4'd12}},
        '{'{4'd7,4'd13,4'd14,4'd3,4'd0,4'd6,4'd9,4'd10,4'd1,4'd2,4'd8,4'd5,4'd11,4'd12,4'd4,4'd15},
          '{4'd13,4'd8,4'd11,4'd5,4'd6,4'd15,4'd0,4'd3,4'd4,4'd7,4'd2,4'd12,4'd1,4'd10,4'd14,4'd9},
          '{4'd10,4'd6,4'd9,4'd0,4'd12,4'd11,4'd7,4'd13,4'd15,4'd1,4'd3,4'd14,4'd5,4'd2,4'd8,4'd4},
          '{4'd3,4'd15,4'd0,4'd6,4'd10,4'd1,4'd13,4'd8,4'd9,4'd4,4'd5,4'd11,4'd12,4'd7,4'd2,4'd14}},
        '{'{4'd2,4'd12,4'd4,4'd1,4'd7,4'd10,4'd11,4'd6,4'd8,4'd5,4'd3,4'd15,4'd13,4'd0,4'd14,4'd9},
          '{4'd14,4'd11,4'd2,4'd12,4'd4,4'd7,4'd13,4'd1,4'd5,4'd0,4'd15,4'd10,4'd3,4'd9,4'd8,4'd6},
          '{4'd4,4'd2,4'd1,4'd11,4'd10,4'd13,4'd7,4'd8,4'd15,4'd9,4'd12,4'd5,4'd6,4'd3,4'd0,4'd14},
          '{4'd11,4'd8,4'd12,4'd7,4'd1,4'd14,4'd2,4'd13,4'd6,4'd15,4'd0,4'd9,4'd10,4'd4,4'd5,4'd3}},
        '{'{4'd12,4'd1,4'd10,4'd15,4'd9,4'd2,4'd6,4'd8,4'd0,4'd13,4'd3,4'd4,4'd14,4'd7,4'd5,4'd11},
          '{4'd10,4'd15,4'd4,4'd2,4'd7,4'd12,4'd9,4'd5,4'd6,4'd1,4'd13,4'd14,4'd0,4'd11,4'd3,4'd8},
          '{4'd9,4'd14,4'd15,4'd5,4'd2,4'd8,4'd12,4'd3,4'd7,4'd0,4'd4,4'd10,4'd1,4'd13,4'd11,4'd6},
          '{4'd4,4'd3,4'd2,4'd12,4'd9,4'd5,4'd15,4'd10,4'd11,4'd14,4'd1,4'd7,4'd6,4'd0,4'd8,4'd13}},
        '{'{4'd4,4'd11,4'd2,4'd14,4'd15,4'd0,4'd8,4'd13,4'd3,4'd12,4'd9,4'd7,4'd5,4'd10,4'd6,4'd1},
          '{4'd13,4'd0,4'd11,4'd7,4'd4,4'd9,4'd1,4'd10,4'd14,4'd3,4'd5,4'd12,4'd2,4'd15,4'd8,4'd6},
          '{4'd1,4'd4,4'd11,4'd13,4'd12,4'd3,4'd7,4'd14,4'd10,4'd15,4'd6,4'd8,4'd0,4'd5,4'd9,4'd2},
          '{4'd6,4'd11,4'd13,4'd8,4'd1,4'd4,4'd10,4'd7,4'd9,4'd5,4'd0,4'd15,4'd14,4'd2,4'd3,4'd12}},
        '{'{4'd13,4'd2,4'd8,4'd4,4'd6,4'd15,4'd11,4'd1,4'd10,4'd9,4'd3,4'd14,4'd5,4'd0,4'd12,4'd7},
          '{4'd1,4'd15,4'd13,4'd8,4'd10,4'd3,4'd7,4'd4,4'd12,4'd5,4'd6,4'd11,4'd0,4'd14,4'd9,4'd2},
          '{4'd7,4'd11,4'd4,4'd1,4'd9,4'd12,4'd14,4'd2,4'd0,4'd6,4'd10,4'd13,4'd15,4'd3,4'd5,4'd8},
          '{4'd2,4'd1,4'd14,4'd7,4'd4,4'd10,4'd8,4'd13,4'd15,4'd12,4'd9,4'd0,4'd3,4'd5,4'd6,4'd11}}
    };

    typedef struct {
        string        name;
        logic [255:0] data;
        int           nbytes;
        logic [63:0]  len;
        bit           gapped;
        bit           holdFinal;
        logic [31:0]  expDigest;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        M_valid;
    logic [7:0]  M;
    logic [63:0] input_lenght;
    logic        hash_ready;
    logic [31:0] digest;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] expQ[$];
    bit          monPrevReady = 1'b0;
    vec_t        vecs [7];

    light_hash_des dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .M_valid      (M_valid),
        .M            (M),
        .input_lenght (input_lenght),
        .hash_ready   (hash_ready),
        .digest       (digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelRound(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] n;
        logic [5:0]  x;
        int          row;
        int          col;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            x   = {b[i], h[4*i +: 4], b[(i + 7) % 8]};
            row = {x[5], x[0]};
            col = x[4:1];
            n[4*i +: 4] = TB_SBOX[i][row][col];
        end
        return ((n << 5) | (n >> 27)) ^ h;
    endfunction

    function automatic logic [31:0] modelDigest(input logic [255:0] data, input int nbytes,
                                                input logic [63:0] len);
        logic [31:0] h;
        logic [63:0] l;
        logic [7:0]  lf;
        h = IV;
        for (int i = 0; i < nbytes; i++) h = modelRound(h, data[8*i +: 8]);
        l  = (len == 64'd0) ? 64'd1 : len;
        lf = 8'h00;
        for (int i = 0; i < 8; i++) lf = lf ^ l[8*i +: 8];
        return modelRound(h, lf);
    endfunction

    function automatic logic [255:0] toPacked(input string s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one message; expects caller to be idle with M_valid low
    task automatic applyStimulus(input vec_t v);
        logic [31:0] prevDigest;
        expQ.push_back(v.expDigest);
        @(negedge clk);
        prevDigest = digest;
        for (int i = 0; i < v.nbytes; i++) begin
            M_valid      = 1'b1;
            M            = v.data[8*i +: 8];
            input_lenght = (i == 0) ? v.len : {$urandom, $urandom};
            @(negedge clk);
            if (i == 0) begin
                checkOutput({v.name, " readyFallsOnFirst"}, 64'(hash_ready), 64'd0);
                checkOutput({v.name, " digestHeldOnFirst"}, 64'(digest), 64'(prevDigest));
            end
            if (v.gapped && i != v.nbytes - 1) begin
                M_valid = 1'b0;
                M       = 8'($urandom);
                @(negedge clk);
            end
        end
        checkOutput({v.name, " readyLowInFinal"}, 64'(hash_ready), 64'd0);
        if (v.holdFinal) begin
            M_valid = 1'b1;
            M       = 8'hA5;
        end else begin
            M_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput({v.name, " readyOneEdgeAfterLast"}, 64'(hash_ready), 64'd1);
        M_valid = 1'b0;
        @(negedge clk);
        checkOutput({v.name, " readyHeldInDone"}, 64'(hash_ready), 64'd1);
        checkOutput({v.name, " digest"}, 64'(digest), 64'(v.expDigest));
    endtask

    // Scoreboard: each rising hash_ready consumes the oldest expected digest
    always @(negedge clk) begin
        if (hash_ready === 1'b1 && !monPrevReady) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboardUnexpectedReady", 64'd1, 64'd0);
            end else begin
                checkOutput("scoreboardDigest", 64'(digest), 64'(expQ.pop_front()));
            end
        end
        monPrevReady = (hash_ready === 1'b1);
    end

    initial begin
        logic [31:0] d1;
        logic [31:0] lenOneDigest;

        d1           = modelDigest(toPacked("Welcome_to_testing"), 18, 64'd18);
        lenOneDigest = modelRound(modelRound(IV, 8'h00), 8'h01);
        vecs[0] = '{"contiguous", toPacked("Welcome_to_testing"), 18, 64'd18, 1'b0, 1'b0, d1};
        vecs[1] = '{"gapped", toPacked("Welcome_to_testing"), 18, 64'd18, 1'b1, 1'b0, d1};
        vecs[2] = '{"oneCharDiff", toPacked("Welcoma_to_testing"), 18, 64'd18, 1'b0, 1'b0,
                    modelDigest(toPacked("Welcoma_to_testing"), 18, 64'd18)};
        vecs[3] = '{"lenOne", 256'h0, 1, 64'd1, 1'b0, 1'b0, lenOneDigest};
        vecs[4] = '{"lenZero", 256'h0, 1, 64'd0, 1'b0, 1'b0, lenOneDigest};
        vecs[5] = '{"validInFinal", toPacked("abc"), 3, 64'd3, 1'b0, 1'b1,
                    modelDigest(toPacked("abc"), 3, 64'd3)};
        vecs[6] = '{"fullWidth", toPacked("0123456789ABCDEF0123456789abcdef"), 32, 64'd32, 1'b1, 1'b1,
                    modelDigest(toPacked("0123456789ABCDEF0123456789abcdef"), 32, 64'd32)};

        rst_n        = 1'b1;
        M_valid      = 1'b0;
        M            = 8'h00;
        input_lenght = 64'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("resetReady", 64'(hash_ready), 64'd0);
        checkOutput("resetDigest", 64'(digest), 64'd0);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k]);
            if (k == 2) begin
                testsRun++;
                if (digest === d1) begin
                    testsFailed++;
                    $display("[TB] FAIL oneCharDiffDiffers: got %0h, required different from %0h", digest, d1);
                end
            end
        end

        // Abort after nine bytes; the byte presented alongside reset must be dropped
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            M_valid      = 1'b1;
            M            = vecs[0].data[8*i +: 8];
            input_lenght = 64'd18;
            @(negedge clk);
        end
        rst_n   = 1'b1;
        M       = 8'h57;
        @(negedge clk);
        rst_n   = 1'b0;
        M_valid = 1'b0;
        checkOutput("midResetReady", 64'(hash_ready), 64'd0);
        checkOutput("midResetDigest", 64'(digest), 64'd0);
        applyStimulus(vecs[0]);

        // One-cycle reset out of DONE clears the registered outputs
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        checkOutput("doneResetReady", 64'(hash_ready), 64'd0);
        checkOutput("doneResetDigest", 64'(digest), 64'd0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
